// File: rtl/note_recorder_if.sv
// Sequence-RAM write port: one packed line plus its address, valid/ready handshake.
// The recorder drives the master side; the RAM (or bench) drives wr_ready.
interface note_recorder_if #(
  parameter int ADDR_W = 4,
  parameter int LINE_W = 15
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/note_recorder.sv
// Records keystrokes quantized to beat ticks as one packed line per beat into sequence RAM; END_MARKER_EN appends an all-3'b111 terminator.
// Latency: keys reach a beat 3 cycles after the pin; a line is offered the cycle after its tick.
// Backpressure: one-entry output slot held stable while !wr_ready; a tick that finds it full drops its line and counts the loss.
module note_recorder #(
  parameter int COLS     = 5,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 21
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              arm,
  input  logic              stop,
  input  logic [COLS-1:0]   keys,
  note_recorder_if.master   wr,
  output logic              recording,
  output logic              done,
  output logic [7:0]        drop_cnt
);
  localparam int LINE_W = 3 * COLS;

`ifdef END_MARKER_EN
  localparam logic MARKER_ON = 1'b1;
`else
  localparam logic MARKER_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RECORD, FLUSH, DONE} state_t;

  state_t              state, state_nxt;
  logic [COLS-1:0]     key_s1, key_s2, key_s3, key_rise, pend;
  logic [TICK_DIV-1:0] tick_cnt;
  logic [LINE_W-1:0]   pend_line, load_dat;
  logic                tick, accept, last_addr, full_hit, slot_free;
  logic                load, drop, enter_rec;
  logic                line_todo, marker_todo;

  always_comb begin
    pend_line = '0;
    for (int c = 0; c < COLS; c++) begin
      pend_line[LINE_W-1-3*c -: 3] = pend[c] ? 3'b001 : 3'b000;
    end
  end

  assign key_rise  = key_s2 & ~key_s3;
  assign tick      = (state == RECORD) && (&tick_cnt);
  assign accept    = wr.wr_valid && wr.wr_ready;
  assign last_addr = &wr.wr_addr;
  assign full_hit  = accept && last_addr;
  assign slot_free = !wr.wr_valid || accept;
  assign recording = (state == RECORD) || (state == FLUSH);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_dat  = pend_line;
    drop      = 1'b0;
    enter_rec = 1'b0;
    case (state)
      IDLE: begin
        if (arm && !stop) begin
          state_nxt = RECORD;
          enter_rec = 1'b1;
        end
      end
      RECORD: begin
        // Accepting the last address ends the take; a tick in that cycle is ignored.
        if (full_hit) begin
          state_nxt = DONE;
        end else begin
          if (tick) begin
            if (slot_free) load = 1'b1;
            else           drop = 1'b1;
          end
          if (stop) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (full_hit) begin
          state_nxt = DONE;
        end else if (line_todo) begin
          load = slot_free;
        end else if (marker_todo) begin
          load     = slot_free;
          load_dat = '1;
        end else if (slot_free) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (arm) begin
          state_nxt = RECORD;
          enter_rec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      key_s1      <= '0;
      key_s2      <= '0;
      key_s3      <= '0;
      pend        <= '0;
      tick_cnt    <= '0;
      line_todo   <= 1'b0;
      marker_todo <= 1'b0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      drop_cnt    <= '0;
    end else begin
      state  <= state_nxt;
      key_s1 <= keys;
      key_s2 <= key_s1;
      key_s3 <= key_s2;

      if (enter_rec)            tick_cnt <= '0;
      else if (state == RECORD) tick_cnt <= tick_cnt + 1'b1;

      // An edge seen on the tick cycle seeds the next beat instead of the closing one.
      if (enter_rec)            pend <= '0;
      else if (state == RECORD) pend <= tick ? key_rise : (pend | key_rise);

      if (enter_rec) begin
        line_todo   <= 1'b0;
        marker_todo <= 1'b0;
      end else if (state == RECORD && state_nxt == FLUSH) begin
        line_todo   <= !tick;
        marker_todo <= MARKER_ON;
      end else if (state == FLUSH && load) begin
        if (line_todo) line_todo   <= 1'b0;
        else           marker_todo <= 1'b0;
      end

      if (load) begin
        wr.wr_valid <= 1'b1;
        wr.wr_data  <= load_dat;
      end else if (accept) begin
        wr.wr_valid <= 1'b0;
      end

      if (enter_rec)   wr.wr_addr <= '0;
      else if (accept) wr.wr_addr <= wr.wr_addr + 1'b1;

      if (enter_rec)                        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with TICK_DIV=3 (8-cycle beats); inputs change and outputs are sampled 1 ns after each rising edge.
module tb_note_recorder;
  localparam int COLS = 5, ADDR_W = 4, TICK_DIV = 3, LINE_W = 15;

  logic              Clk = 1'b0;
  logic              Reset, arm, stop;
  logic [COLS-1:0]   keys;
  logic              recording, done;
  logic [7:0]        drop_cnt;

  note_recorder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) wr_if();

  note_recorder #(.COLS(COLS), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .Clk(Clk), .Reset(Reset), .arm(arm), .stop(stop), .keys(keys),
    .wr(wr_if.master), .recording(recording), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [COLS-1:0]   keys;
    logic [LINE_W-1:0] line;
  } vec_t;

  vec_t vecs [6];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; arm = 1'b0; stop = 1'b0; keys = '0; wr_if.wr_ready = 1'b1;
    step(2);
    Reset = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic press(input logic [COLS-1:0] m);
    keys = m;
    step(2);
    keys = '0;
  endtask

  // Waits for an offered-and-ready line, checks it, then lets the accept edge pass.
  task automatic wait_write(input int a, input logic [LINE_W-1:0] d, input string name);
    int t = 0;
    while (!(wr_if.wr_valid && wr_if.wr_ready) && t < 40) begin
      step();
      t++;
    end
    if (t >= 40) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: got no write in 40 cycles, expected addr %0d data %0h", name, a, d);
    end else begin
      check({name, "_addr"}, 32'(wr_if.wr_addr), 32'(a));
      check({name, "_data"}, 32'(wr_if.wr_data), 32'(d));
      step();
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    int extra = 0;
    while (!done && t < 40) begin
      if (wr_if.wr_valid && wr_if.wr_ready) extra++;
      step();
      t++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_extra_writes"}, 32'(extra), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{keys: 5'b00001, line: 15'h1000};
    vecs[1] = '{keys: 5'b00000, line: 15'h0000};
    vecs[2] = '{keys: 5'b00000, line: 15'h0000};
    vecs[3] = '{keys: 5'b10010, line: 15'h0201};
    vecs[4] = '{keys: 5'b11111, line: 15'h1249};
    vecs[5] = '{keys: 5'b00100, line: 15'h0040};

    // Reset values and stop-while-idle.
    do_reset();
    check("rst_valid", 32'(wr_if.wr_valid), 32'd0);
    check("rst_addr",  32'(wr_if.wr_addr),  32'd0);
    check("rst_data",  32'(wr_if.wr_data),  32'd0);
    check("rst_rec",   32'(recording),      32'd0);
    check("rst_done",  32'(done),           32'd0);
    check("rst_drop",  32'(drop_cnt),       32'd0);
    stop = 1'b1; step(); stop = 1'b0; step(2);
    check("idle_stop_rec", 32'(recording), 32'd0);

    // One key pattern per beat, one line per beat.
    arm_pulse();
    check("arm_rec", 32'(recording), 32'd1);
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].keys);
      wait_write(i, vecs[i].line, $sformatf("vec%0d", i));
    end
    check("vec_drop", 32'(drop_cnt), 32'd0);

    // Edge on the tick cycle lands in the following beat.
    do_reset(); arm_pulse();
    press(5'b10010);
    step(3);
    press(5'b00100);
    wait_write(0, 15'h0201, "coinc_l0");
    wait_write(1, 15'h0040, "coinc_l1");

    // Back-pressure across a tick: held line stays put, next beat is dropped.
    do_reset(); arm_pulse();
    press(5'b01000);
    step(3);
    wr_if.wr_ready = 1'b0;
    step(3);
    check("hold_valid0", 32'(wr_if.wr_valid), 32'd1);
    check("hold_data0",  32'(wr_if.wr_data),  32'h0008);
    press(5'b00001);
    step(6);
    check("hold_valid1", 32'(wr_if.wr_valid), 32'd1);
    check("hold_data1",  32'(wr_if.wr_data),  32'h0008);
    check("hold_addr1",  32'(wr_if.wr_addr),  32'd0);
    check("hold_drop",   32'(drop_cnt),       32'd1);
    step();
    wr_if.wr_ready = 1'b1;
    wait_write(0, 15'h0008, "bp_l0");
    wait_write(1, 15'h0000, "bp_l1");
    check("bp_drop_after", 32'(drop_cnt), 32'd1);

    // Fill all 16 addresses, then re-arm from DONE.
    do_reset(); arm_pulse();
    for (int i = 0; i < 16; i++) wait_write(i, 15'h0000, $sformatf("full%0d", i));
    check("full_done",  32'(done),           32'd1);
    check("full_rec",   32'(recording),      32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (wr_if.wr_valid) seen++;
        step();
      end
      check("full_quiet", 32'(seen), 32'd0);
    end
    arm_pulse();
    check("rearm_done", 32'(done),          32'd0);
    check("rearm_rec",  32'(recording),     32'd1);
    check("rearm_drop", 32'(drop_cnt),      32'd0);
    wait_write(0, 15'h0000, "rearm_l0");

    // Reset while a line is being offered.
    do_reset(); arm_pulse();
    press(5'b00001);
    wr_if.wr_ready = 1'b0;
    step(6);
    check("mid_pre_valid", 32'(wr_if.wr_valid), 32'd1);
    Reset = 1'b1;
    step();
    check("mid_valid", 32'(wr_if.wr_valid), 32'd0);
    check("mid_addr",  32'(wr_if.wr_addr),  32'd0);
    check("mid_data",  32'(wr_if.wr_data),  32'd0);
    check("mid_rec",   32'(recording),      32'd0);
    check("mid_done",  32'(done),           32'd0);
    check("mid_drop",  32'(drop_cnt),       32'd0);
    Reset = 1'b0;

    // Stop on the second tick: that line is final, no flush line.
    do_reset(); arm_pulse();
    wait_write(0, 15'h0000, "stopt_l0");
    step(6);
    stop = 1'b1; step(); stop = 1'b0;
    wait_write(1, 15'h0000, "stopt_l1");
`ifdef END_MARKER_EN
    wait_write(2, 15'h7FFF, "stopt_mark");
`endif
    wait_done("stopt");

    // Stop mid-beat: pending keys become a flush line.
    do_reset(); arm_pulse();
    wait_write(0, 15'h0000, "stopf_l0");
    wait_write(1, 15'h0000, "stopf_l1");
    press(5'b10000);
    step(2);
    stop = 1'b1; step(); stop = 1'b0;
    wait_write(2, 15'h0001, "stopf_flush");
`ifdef END_MARKER_EN
    wait_write(3, 15'h7FFF, "stopf_mark");
`endif
    wait_done("stopf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
